// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the simple processor front end.
//   DATA_WIDTH : IMEM read word width (two 16-bit instructions per word)
//   ADDR_WIDTH : IMEM byte address width
//   func_t     : 4-bit operation code held in instr[3:0]
package simple_processor_pkg;

    parameter int unsigned DATA_WIDTH = 32;
    parameter int unsigned ADDR_WIDTH = 16;

    typedef enum logic [3:0] {
        FuncAdd   = 4'h0,
        FuncSub   = 4'h1,
        FuncAnd   = 4'h2,
        FuncOr    = 4'h3,
        FuncXor   = 4'h4,
        FuncNot   = 4'h5,
        FuncAddi  = 4'h6,
        FuncLoad  = 4'h7,
        FuncStore = 4'h8,
        FuncSll   = 4'h9,
        FuncSlr   = 4'hA,
        FuncSlli  = 4'hB,
        FuncSlri  = 4'hC,
        FuncBeq   = 4'hD,
        FuncJmp   = 4'hE,
        FuncHalt  = 4'hF
    } func_t;

endpackage

// File: rtl/ins_dec_q.sv
// ins_dec_q -- instruction fetch queue with combinational decode of the head entry.
//
// Fetched IMEM words are split by imem_addr_i[1] into a 16-bit instruction, queued
// together with the fetch address, and the oldest entry is presented decoded.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_rdata_i/addr_i   fetch word and its byte address
//   imem_ack_i, ready_o   fetch strobe / queue not full
//   flush_i               drop every queued entry
//   dec_valid_o/ready_i   head handshake
//   func_o .. valid_pc_o  decoded head fields (all zero when queue empty)
//   pc_o                  fetch address of the head entry
//   count_o               occupancy
//   illegal_cnt_o         saturating count of popped non-executable entries
//                         (present only with INS_DEC_ILLEGAL_CNT_EN defined)
module ins_dec_q #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         imem_rdata_i,
    input  logic [ADDR_WIDTH-1:0]         imem_addr_i,
    input  logic                          imem_ack_i,
    output logic                          ready_o,
    input  logic                          flush_i,
    output logic                          dec_valid_o,
    input  logic                          dec_ready_i,
    output simple_processor_pkg::func_t   func_o,
    output logic                          we_o,
    output logic [2:0]                    rd_addr_o,
    output logic [2:0]                    rs1_addr_o,
    output logic [2:0]                    rs2_addr_o,
    output logic [5:0]                    imm_o,
    output logic                          valid_pc_o,
    output logic [ADDR_WIDTH-1:0]         pc_o,
    output logic [$clog2(DEPTH):0]        count_o
`ifdef INS_DEC_ILLEGAL_CNT_EN
    ,
    output logic [15:0]                   illegal_cnt_o
`endif
);

    import simple_processor_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]           r_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic [15:0] w_instr_in;
    logic [15:0] w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_exec;

    assign w_instr_in  = imem_addr_i[1] ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    assign ready_o     = (r_count != CNT_W'(DEPTH));
    assign dec_valid_o = (r_count != '0);
    assign count_o     = r_count;

    // Flush outranks both handshakes; a full queue refuses the fetch even when
    // the head is popped in the same cycle.
    assign w_push = imem_ack_i & ready_o & ~flush_i;
    assign w_pop  = dec_valid_o & dec_ready_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_instr[r_wptr] <= w_instr_in;
            r_pc[r_wptr]    <= imem_addr_i;
        end
    end

    assign w_head = r_instr[r_rptr];

    always_comb begin
        w_exec = 1'b0;
        case (func_t'(w_head[3:0]))
            FuncAddi, FuncAdd, FuncSub, FuncAnd, FuncOr, FuncXor, FuncNot,
            FuncLoad, FuncStore, FuncSll, FuncSlr, FuncSlli, FuncSlri: w_exec = 1'b1;
            default: w_exec = 1'b0;
        endcase
    end

    always_comb begin
        func_o     = FuncAdd;
        we_o       = 1'b0;
        rd_addr_o  = '0;
        rs1_addr_o = '0;
        rs2_addr_o = '0;
        imm_o      = '0;
        valid_pc_o = 1'b0;
        pc_o       = '0;
        if (dec_valid_o) begin
            func_o     = func_t'(w_head[3:0]);
            rd_addr_o  = w_head[15:13];
            rs1_addr_o = w_head[12:10];
            rs2_addr_o = w_head[9:7];
            imm_o      = w_head[9:4];
            valid_pc_o = w_exec;
            we_o       = w_exec && (w_head[3:0] != FuncStore);
            pc_o       = r_pc[r_rptr];
        end
    end

`ifdef INS_DEC_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_cnt;

    // Survives flush on purpose: it tracks history, not queue contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_illegal_cnt <= '0;
        end else if (w_pop && !w_exec && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign illegal_cnt_o = r_illegal_cnt;
`else
    // Illegal-pop counter not built.
`endif

endmodule

// File: tb/tb_ins_dec_q.sv
module tb_ins_dec_q;

    import simple_processor_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_i;
    logic [31:0] imem_rdata_i;
    logic [15:0] imem_addr_i;
    logic        imem_ack_i;
    logic        ready_o;
    logic        flush_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    func_t       func_o;
    logic        we_o;
    logic [2:0]  rd_addr_o;
    logic [2:0]  rs1_addr_o;
    logic [2:0]  rs2_addr_o;
    logic [5:0]  imm_o;
    logic        valid_pc_o;
    logic [15:0] pc_o;
    logic [2:0]  count_o;
`ifdef INS_DEC_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_o;
`endif

    ins_dec_q #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_addr_i  (imem_addr_i),
        .imem_ack_i   (imem_ack_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .func_o       (func_o),
        .we_o         (we_o),
        .rd_addr_o    (rd_addr_o),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .imm_o        (imm_o),
        .valid_pc_o   (valid_pc_o),
        .pc_o         (pc_o),
        .count_o      (count_o)
`ifdef INS_DEC_ILLEGAL_CNT_EN
        ,
        .illegal_cnt_o(illegal_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mq_ins[$];
    logic [15:0] mq_pc[$];
    int          m_illegal = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference decode: {func, we, valid_pc, rd, rs1, rs2, imm}
    function automatic logic [20:0] exp_dec(input logic [15:0] ins);
        logic v;
        logic w;
        case (func_t'(ins[3:0]))
            FuncAddi, FuncAdd, FuncSub, FuncAnd, FuncOr, FuncXor, FuncNot,
            FuncLoad, FuncStore, FuncSll, FuncSlr, FuncSlli, FuncSlri: v = 1'b1;
            default: v = 1'b0;
        endcase
        w = v && (func_t'(ins[3:0]) != FuncStore);
        return {ins[3:0], w, v, ins[15:13], ins[12:10], ins[9:7], ins[9:4]};
    endfunction

    task automatic check_head(input string tag);
        logic [20:0] e_dec;
        logic [15:0] e_pc;
        e_dec = '0;
        e_pc  = '0;
        if (mq_ins.size() != 0) begin
            e_dec = exp_dec(mq_ins[0]);
            e_pc  = mq_pc[0];
        end
        check({tag, "_cnt"}, 32'(count_o), 32'(mq_ins.size()));
        check({tag, "_valid"}, 32'(dec_valid_o), 32'(mq_ins.size() != 0));
        check({tag, "_ready"}, 32'(ready_o), 32'(mq_ins.size() != DEPTH));
        check({tag, "_dec"},
              32'({4'(func_o), we_o, valid_pc_o, rd_addr_o, rs1_addr_o, rs2_addr_o, imm_o}),
              32'(e_dec));
        check({tag, "_pc"}, 32'(pc_o), 32'(e_pc));
    endtask

    // One clock: inputs applied at the falling edge, model stepped at the rising edge.
    task automatic cycle(input logic ack, input logic [15:0] addr, input logic [31:0] rdata,
                         input logic rdy, input logic fl, input logic rs);
        logic [15:0] ins;
        logic        do_push;
        logic        do_pop;
        logic [20:0] hd;
        imem_ack_i   = ack;
        imem_addr_i  = addr;
        imem_rdata_i = rdata;
        dec_ready_i  = rdy;
        flush_i      = fl;
        rst_i        = rs;
        ins = addr[1] ? rdata[31:16] : rdata[15:0];
        @(posedge clk);
        if (rs) begin
            mq_ins.delete();
            mq_pc.delete();
            m_illegal = 0;
        end else if (fl) begin
            mq_ins.delete();
            mq_pc.delete();
        end else begin
            do_pop  = (mq_ins.size() != 0) && rdy;
            do_push = ack && (mq_ins.size() != DEPTH);
            if (do_pop) begin
                hd = exp_dec(mq_ins[0]);
                if (!hd[15] && m_illegal != 16'hFFFF) m_illegal++;
                void'(mq_ins.pop_front());
                void'(mq_pc.pop_front());
            end
            if (do_push) begin
                mq_ins.push_back(ins);
                mq_pc.push_back(addr);
            end
        end
        @(negedge clk);
        imem_ack_i = 1'b0;
        dec_ready_i = 1'b0;
        flush_i = 1'b0;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        imem_rdata_i = '0;
        imem_addr_i  = '0;
        imem_ack_i   = 1'b0;
        flush_i      = 1'b0;
        dec_ready_i  = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_head("rst");
        check("rst_ready_const", 32'(ready_o), 32'd1);

        // Upper halfword selected by addr[1]
        cycle(1'b1, 16'h0002, 32'hABCD1234, 1'b0, 1'b0, 1'b0);
        check_head("hi");
        check("hi_rd", 32'(rd_addr_o), 32'd5);
        check("hi_rs1", 32'(rs1_addr_o), 32'd2);
        check("hi_rs2", 32'(rs2_addr_o), 32'd7);
        check("hi_imm", 32'(imm_o), 32'h3C);
        check("hi_func", 32'(func_o), 32'hD);
        check("hi_pc", 32'(pc_o), 32'h2);
        check("hi_we", 32'(we_o), 32'd0);
        check("hi_vpc", 32'(valid_pc_o), 32'd0);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_head("hi_pop");

        // Lower halfword
        cycle(1'b1, 16'h0000, 32'hABCD1234, 1'b0, 1'b0, 1'b0);
        check("lo_rd", 32'(rd_addr_o), 32'd0);
        check("lo_rs1", 32'(rs1_addr_o), 32'd4);
        check("lo_rs2", 32'(rs2_addr_o), 32'd4);
        check("lo_imm", 32'(imm_o), 32'h23);
        check("lo_func", 32'(func_o), 32'h4);
        check("lo_we", 32'(we_o), 32'd1);
        check("lo_vpc", 32'(valid_pc_o), 32'd1);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_head("lo_pop");

        // Fill past capacity; fifth fetch is dropped
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'(16'h0100 + 4 * i), {16'h0, 16'(16'h2000 + 16 * i + 3)},
                  1'b0, 1'b0, 1'b0);
            check_head("fill");
            if (i == 3) check("fill_ready4", 32'(ready_o), 32'd0);
        end
        check("fill_cnt", 32'(count_o), 32'd4);
        check("fill_head_pc", 32'(pc_o), 32'h0100);

        // Full: pop happens, the fetch is refused because ready_o is low
        cycle(1'b1, 16'h0200, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        check_head("full_pp");
        check("full_pp_cnt", 32'(count_o), 32'd3);
        check("full_pp_pc", 32'(pc_o), 32'h0104);

        // Half-full push+pop keeps occupancy
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0300, 32'h0000_6667, 1'b1, 1'b0, 1'b0);
        check_head("half_pp");
        check("half_pp_cnt", 32'(count_o), 32'd2);
        for (int i = 0; i < 8 && mq_ins.size() != 0; i++) begin
            cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            check_head("drain");
        end

        // Flush beats a simultaneous fetch
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(4 * i), 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0040, 32'h1111_2222, 1'b1, 1'b1, 1'b0);
        check_head("flush");
        check("flush_valid", 32'(dec_valid_o), 32'd0);

        // Reset beats a simultaneous fetch
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(4 * i), 32'h0000_000E, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0040, 32'h1111_2222, 1'b1, 1'b0, 1'b1);
        check_head("rst2");
        check("rst2_cnt", 32'(count_o), 32'd0);
`ifdef INS_DEC_ILLEGAL_CNT_EN
        check("rst2_illegal", 32'(illegal_cnt_o), 32'd0);
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom), 16'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 49) == 0), 1'b0);
            check_head("rnd");
        end
`ifdef INS_DEC_ILLEGAL_CNT_EN
        check("rnd_illegal", 32'(illegal_cnt_o), 32'(m_illegal));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
